// File: rtl/lock_access_arbiter.sv
// Round-robin arbiter that lends one serial-entry lock to NUM_SRC keypads,
// one complete code-entry session at a time, and sequences flush/relock/lockout.
module lock_access_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter int         CODE_LEN     = 4,
  parameter int         IDLE_TIMEOUT = 50_000,
  parameter int         UNLOCK_HOLD  = 1_000_000,
  parameter logic [3:0] PAD_DIGIT    = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_SRC-1:0]   src_digit,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC-1:0]     src_relock,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic [NUM_SRC-1:0]     src_drop_pulse,
  output logic [2:0]             owner_id,
  output logic                   timeout_pulse,
  output logic [3:0]             lk_digit,
  output logic                   lk_valid,
  output logic                   lk_relock,
  input  logic                   lk_unlocked,
  input  logic                   lk_wrong_try_pulse,
  input  logic                   lk_lockout
);

  localparam int TMAX = (IDLE_TIMEOUT > UNLOCK_HOLD) ? IDLE_TIMEOUT : UNLOCK_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int IW   = $clog2(NUM_SRC);

  typedef enum logic [2:0] {
    S_IDLE, S_SESSION, S_FLUSH, S_SETTLE, S_OPEN, S_RELOCK, S_BLOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [2:0]           owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmr_q, tmr_d, tmr_inc;
  logic [NUM_SRC-1:0]   grant_q, grant_d, drop_q, drop_d, win_mask;
  logic                 to_q, to_d, lkv_q, lkv_d, rel_q, rel_d;
  logic [3:0]           lkd_q, lkd_d;
  logic [IW-1:0]        win;
  logic                 own_strobe, own_relock;
  logic [NUM_SRC-1:0][3:0] dig;

  assign dig = src_digit;

  // First requester at or above ptr, wrapping; lowest offset wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [IW-1:0]      ptr);
    int idx;
    rr_pick = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx -= NUM_SRC;
      if (req[idx[IW-1:0]]) rr_pick = idx[IW-1:0];
    end
  endfunction

  assign win        = rr_pick(src_valid, rr_q);
  assign win_mask   = NUM_SRC'(1) << win;
  assign own_strobe = |(src_valid & grant_q);
  assign own_relock = |(src_relock & grant_q);
  assign tmr_inc    = (&tmr_q) ? tmr_q : tmr_q + TW'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    grant_d = grant_q;
    drop_d  = src_valid;  // anything not forwarded below is discarded
    to_d    = 1'b0;
    lkv_d   = 1'b0;
    lkd_d   = lkd_q;
    rel_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|src_valid) begin
          state_d = S_SESSION;
          grant_d = win_mask;
          owner_d = 3'(win);
          drop_d  = src_valid & ~win_mask;
          lkv_d   = 1'b1;
          lkd_d   = dig[win];
          cnt_d   = CW'(1);
          tmr_d   = '0;
          rr_d    = (win == IW'(NUM_SRC - 1)) ? '0 : win + IW'(1);
        end
      end
      S_SESSION: begin
        // A strobe racing the timeout expiry is forwarded, not flushed.
        if (lk_wrong_try_pulse || cnt_q == CW'(CODE_LEN)) begin
          state_d = S_SETTLE;
        end else if (own_strobe) begin
          drop_d = src_valid & ~grant_q;
          lkv_d  = 1'b1;
          lkd_d  = dig[owner_q[IW-1:0]];
          cnt_d  = (cnt_q == CW'(CODE_LEN)) ? cnt_q : cnt_q + CW'(1);
          tmr_d  = '0;
        end else if (tmr_q == TW'(IDLE_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          lkv_d   = 1'b1;
          lkd_d   = PAD_DIGIT;
          state_d = S_FLUSH;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_FLUSH: begin
        if (lk_wrong_try_pulse) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (lk_unlocked) begin
          state_d = S_OPEN;
          tmr_d   = '0;
        end else if (lk_lockout) begin
          state_d = S_BLOCKED;
          grant_d = '0;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_OPEN: begin
        if (own_relock || tmr_q == TW'(UNLOCK_HOLD - 1)) begin
          rel_d   = 1'b1;
          state_d = S_RELOCK;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_RELOCK: begin
        if (!lk_unlocked) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_BLOCKED: begin
        grant_d = '0;
        if (!lk_lockout) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      grant_q <= '0;
      drop_q  <= '0;
      to_q    <= 1'b0;
      lkv_q   <= 1'b0;
      lkd_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
      lkv_q   <= lkv_d;
      lkd_q   <= lkd_d;
      rel_q   <= rel_d;
    end
  end

  assign src_grant      = grant_q;
  assign src_drop_pulse = drop_q;
  assign owner_id       = owner_q;
  assign timeout_pulse  = to_q;
  assign lk_digit       = lkd_q;
  assign lk_valid       = lkv_q;
  assign lk_relock      = rel_q;

endmodule

// File: tb/tb_lock_access_arbiter.sv
// Random keypad traffic against a small lock model; every output is compared
// each cycle with a rule-level reference model of the arbiter.
module tb_lock_access_arbiter;

  localparam int         N   = 4;
  localparam int         CL  = 4;
  localparam int         IT  = 8;
  localparam int         UH  = 16;
  localparam logic [3:0] PAD = 4'hF;

  logic           clk, rst_n;
  logic [4*N-1:0] src_digit;
  logic [N-1:0]   src_valid, src_relock, src_grant, src_drop_pulse;
  logic [2:0]     owner_id;
  logic           timeout_pulse, lk_valid, lk_relock;
  logic [3:0]     lk_digit;
  logic           lk_unlocked, lk_wrong_try_pulse, lk_lockout;

  lock_access_arbiter #(
    .NUM_SRC(N), .CODE_LEN(CL), .IDLE_TIMEOUT(IT), .UNLOCK_HOLD(UH), .PAD_DIGIT(PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_digit(src_digit), .src_valid(src_valid), .src_relock(src_relock),
    .src_grant(src_grant), .src_drop_pulse(src_drop_pulse), .owner_id(owner_id),
    .timeout_pulse(timeout_pulse), .lk_digit(lk_digit), .lk_valid(lk_valid),
    .lk_relock(lk_relock), .lk_unlocked(lk_unlocked),
    .lk_wrong_try_pulse(lk_wrong_try_pulse), .lk_lockout(lk_lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lock: passcode 1,2,3,4 checked digit by digit, 3 wrong tries -> lockout.
  int l_idx, l_att, l_lo_cnt, l_rl_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      l_idx <= 0; l_att <= 0; l_lo_cnt <= 0; l_rl_cnt <= 0;
      lk_unlocked <= 1'b0; lk_wrong_try_pulse <= 1'b0; lk_lockout <= 1'b0;
    end else begin
      lk_wrong_try_pulse <= 1'b0;
      if (l_rl_cnt != 0) begin
        l_rl_cnt <= l_rl_cnt - 1;
        if (l_rl_cnt == 1) lk_unlocked <= 1'b0;
      end
      if (lk_relock) l_rl_cnt <= 2;
      if (lk_lockout) begin
        if (l_lo_cnt == 0) lk_lockout <= 1'b0;
        else l_lo_cnt <= l_lo_cnt - 1;
      end else if (lk_valid && !lk_unlocked && !lk_wrong_try_pulse) begin
        if (lk_digit == 4'(l_idx + 1)) begin
          if (l_idx == CL - 1) begin
            lk_unlocked <= 1'b1; l_idx <= 0; l_att <= 0;
          end else l_idx <= l_idx + 1;
        end else begin
          lk_wrong_try_pulse <= 1'b1;
          l_idx <= 0;
          if (l_att == 2) begin
            lk_lockout <= 1'b1; l_lo_cnt <= 20; l_att <= 0;
          end else l_att <= l_att + 1;
        end
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase names, owner, rr pointer, digits entered, timer.
  string      ph = "idle";
  int         m_rr = 0, m_owner = 0, m_cnt = 0, m_tmr = 0;
  logic [N-1:0] e_grant = '0, e_drop = '0;
  logic [2:0] e_owner = '0;
  logic       e_to = 1'b0, e_lkv = 1'b0, e_rel = 1'b0;
  logic [3:0] e_lkd = '0;
  int         seen_open = 0, seen_block = 0, seen_to = 0, seen_tie = 0;

  task automatic model_step();
    int  w;
    bit  found;
    e_drop = src_valid; e_to = 1'b0; e_lkv = 1'b0; e_rel = 1'b0;
    if (!rst_n) begin
      ph = "idle"; m_rr = 0; m_owner = 0; m_cnt = 0; m_tmr = 0;
      e_grant = '0; e_drop = '0; e_owner = '0; e_lkd = '0;
      return;
    end
    if (ph == "idle") begin
      e_grant = '0;
      if (|src_valid) begin
        found = 0; w = 0;
        for (int k = 0; k < N; k++)
          if (!found && src_valid[(m_rr + k) % N]) begin found = 1; w = (m_rr + k) % N; end
        if ($countones(src_valid) > 1) seen_tie++;
        m_owner = w; e_owner = 3'(w);
        e_grant = '0; e_grant[w] = 1'b1;
        e_drop = src_valid & ~e_grant;
        e_lkv = 1'b1; e_lkd = src_digit[4*w +: 4];
        m_cnt = 1; m_tmr = 0; m_rr = (w + 1) % N;
        ph = "session";
      end
    end else if (ph == "session") begin
      if (lk_wrong_try_pulse || m_cnt == CL) ph = "settle";
      else if (src_valid[m_owner]) begin
        e_drop = src_valid & ~e_grant;
        e_lkv = 1'b1; e_lkd = src_digit[4*m_owner +: 4];
        m_cnt++; m_tmr = 0;
      end else if (m_tmr == IT - 1) begin
        e_to = 1'b1; e_lkv = 1'b1; e_lkd = PAD; ph = "flush"; seen_to++;
      end else m_tmr++;
    end else if (ph == "flush") begin
      if (lk_wrong_try_pulse) ph = "settle";
    end else if (ph == "settle") begin
      if (lk_unlocked) begin ph = "open"; m_tmr = 0; seen_open++; end
      else if (lk_lockout) begin ph = "blocked"; e_grant = '0; seen_block++; end
      else begin ph = "idle"; e_grant = '0; end
    end else if (ph == "open") begin
      if (src_relock[m_owner] || m_tmr == UH - 1) begin e_rel = 1'b1; ph = "relock"; end
      else m_tmr++;
    end else if (ph == "relock") begin
      if (!lk_unlocked) begin ph = "idle"; e_grant = '0; end
    end else begin
      e_grant = '0;
      if (!lk_lockout) ph = "idle";
    end
  endtask

  initial begin
    int  quiet = 0, p;
    bit  mid_done = 0;
    rst_n = 1'b0; src_digit = '0; src_valid = '0; src_relock = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      chk("grant", 32'(src_grant), 32'(e_grant));
      chk("drop",  32'(src_drop_pulse), 32'(e_drop));
      chk("owner", 32'(owner_id), 32'(e_owner));
      chk("tmo",   32'(timeout_pulse), 32'(e_to));
      chk("lkv",   32'(lk_valid), 32'(e_lkv));
      chk("rel",   32'(lk_relock), 32'(e_rel));
      if (e_lkv || cyc < 3) chk("lkd", 32'(lk_digit), 32'(e_lkd));
      // next-cycle stimulus
      rst_n = (cyc >= 2);
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 39) == 0) quiet = 12;
      for (int i = 0; i < N; i++) begin
        p = (ph == "session" && i == m_owner) ? 2 : 4;
        src_valid[i]  = (quiet == 0) && ($urandom_range(0, p - 1) == 0);
        src_relock[i] = ($urandom_range(0, 15) == 0);
        if (ph == "session" && i == m_owner && $urandom_range(0, 7) != 0)
          src_digit[4*i +: 4] = 4'(m_cnt + 1);
        else
          src_digit[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if (!mid_done && cyc > 800 && ph == "session" && m_cnt == 2) begin
        rst_n = 1'b0; mid_done = 1;
      end
      model_step();
    end
    chk("cov_open",    32'(seen_open > 0), 32'd1);
    chk("cov_block",   32'(seen_block > 0), 32'd1);
    chk("cov_timeout", 32'(seen_to > 0), 32'd1);
    chk("cov_tie",     32'(seen_tie > 0), 32'd1);
    chk("cov_midrst",  32'(mid_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
